// File: rtl/serial_chunk_adder_if.sv
// Start/busy/done handshake and operand bundle for serial_chunk_adder.
// The op signal exists only when SERIAL_SUB_EN is defined.
interface serial_chunk_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_EN
  logic             op;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH:0]   s;
  logic             ovf;

`ifdef SERIAL_SUB_EN
  modport master (output start, a, b, op, input busy, done, s, ovf);
  modport slave  (input start, a, b, op, output busy, done, s, ovf);
`else
  modport master (output start, a, b, input busy, done, s, ovf);
  modport slave  (input start, a, b, output busy, done, s, ovf);
`endif
endinterface

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder, CHUNK bits per clock, LS chunk first, start/busy/done handshake.
// Optional subtract mode (op port, B inverted with carry-in 1) under SERIAL_SUB_EN.
//
// state | meaning
// IDLE  | reset state, waiting for start
// RUN   | one chunk added per clock, L = WIDTH/CHUNK cycles
// DONE  | one-cycle completion pulse; start here chains the next operation
module serial_chunk_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_chunk_adder_if.slave bus
);
  localparam int L  = WIDTH / CHUNK;
  localparam int CW = (L > 1) ? $clog2(L) : 1;

  if (((WIDTH % CHUNK) != 0) || (WIDTH < 2)) begin : g_param_check
    $error("serial_chunk_adder: CHUNK must divide WIDTH and WIDTH must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic [WIDTH-1:0]       res_q, res_d;
  logic                   carry_q, carry_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH:0]         s_q, s_d;
  logic                   ovf_q, ovf_d;
  logic                   a_msb_q, a_msb_d;
  logic                   b_msb_q, b_msb_d;

  logic                   sub;
  logic [CHUNK:0]         sum;
  logic [WIDTH+CHUNK-1:0] res_cat;
  logic [WIDTH-1:0]       res_next;

`ifdef SERIAL_SUB_EN
  assign sub = bus.op;
`else
  assign sub = 1'b0;
`endif

  assign sum      = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
  // Concatenate-and-slice so CHUNK == WIDTH needs no special case.
  assign res_cat  = {sum[CHUNK-1:0], res_q};
  assign res_next = res_cat[WIDTH+CHUNK-1:CHUNK];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    ovf_d   = ovf_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = sub ? ~bus.b : bus.b;
          carry_d = sub;
          cnt_d   = '0;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1] ^ sub;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        res_d   = res_next;
        carry_d = sum[CHUNK];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(L - 1)) begin
          s_d     = {sum[CHUNK], res_next};
          ovf_d   = (a_msb_q ~^ b_msb_q) & (a_msb_q ^ res_next[WIDTH-1]);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      ovf_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      ovf_q   <= ovf_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.s    = s_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_chunk_adder.sv
// Bench for serial_chunk_adder: an 8-bit/2-bit-chunk instance and a 5-bit single-chunk
// instance, checked against an integer-arithmetic reference model.
module tb_serial_chunk_adder;
  localparam int L8 = 4;

`ifdef SERIAL_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   prev_s8 = 0;
  bit   prev_ov8 = 1'b0;

  serial_chunk_adder_if #(.WIDTH(8)) bus8 ();
  serial_chunk_adder_if #(.WIDTH(5)) bus5 ();

  serial_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  serial_chunk_adder #(.WIDTH(5), .CHUNK(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic void ref_calc(input int w, input int ia, input int ib, input bit sub,
                                   output int s, output bit ov);
    int mask = (1 << w) - 1;
    int half = 1 << (w - 1);
    int sa   = (ia >= half) ? ia - (1 << w) : ia;
    int sb   = (ib >= half) ? ib - (1 << w) : ib;
    int sr;
    if (sub) begin
      s  = ((ia >= ib) ? (1 << w) : 0) | ((ia - ib) & mask);
      sr = sa - sb;
    end else begin
      s  = ia + ib;
      sr = sa + sb;
    end
    ov = (sr >= half) || (sr < -half);
  endfunction

  // Called just after an edge with the DUT idle or in its done cycle; returns in the done cycle.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input bit sub);
    int s_exp;
    bit ov_exp;
    int n;
    ref_calc(8, int'(av), int'(bv), sub, s_exp, ov_exp);
    bus8.a     = av;
    bus8.b     = bv;
    bus8.start = 1'b1;
`ifdef SERIAL_SUB_EN
    bus8.op    = sub;
`endif
    @(posedge clk); #1;
    check_eq("accept_busy", bus8.busy, 1'b1);
    check_eq("hold_s", bus8.s, prev_s8);
    check_eq("hold_ovf", bus8.ovf, prev_ov8);
    n = 0;
    while (bus8.busy && n < 50) begin
      check_eq("busy_done_excl", bus8.done, 1'b0);
      bus8.start = 1'($urandom);
      bus8.a     = 8'($urandom);
      bus8.b     = 8'($urandom);
`ifdef SERIAL_SUB_EN
      bus8.op    = 1'($urandom);
`endif
      @(posedge clk); #1;
      n++;
    end
    bus8.start = 1'b0;
    check_eq("latency", n, L8);
    check_eq("done_pulse", bus8.done, 1'b1);
    check_eq("s", bus8.s, s_exp);
    check_eq("ovf", bus8.ovf, ov_exp);
    prev_s8  = s_exp;
    prev_ov8 = ov_exp;
  endtask

  task automatic idle8();
    @(posedge clk); #1;
    check_eq("done_single", bus8.done, 1'b0);
    check_eq("idle_busy", bus8.busy, 1'b0);
  endtask

  task automatic op5(input logic [4:0] av, input logic [4:0] bv);
    int s_exp;
    bit ov_exp;
    ref_calc(5, int'(av), int'(bv), 1'b0, s_exp, ov_exp);
    bus5.a     = av;
    bus5.b     = bv;
    bus5.start = 1'b1;
    @(posedge clk); #1;
    bus5.start = 1'b0;
    check_eq("w5_busy", bus5.busy, 1'b1);
    @(posedge clk); #1;
    check_eq("w5_done", bus5.done, 1'b1);
    check_eq("w5_s", bus5.s, s_exp);
    check_eq("w5_ovf", bus5.ovf, ov_exp);
    @(posedge clk); #1;
    check_eq("w5_idle", bus5.done | bus5.busy, 1'b0);
  endtask

  initial begin
    bit saw_done;
    rst_n      = 1'b0;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus5.start = 1'b0;
    bus5.a     = '0;
    bus5.b     = '0;
`ifdef SERIAL_SUB_EN
    bus8.op    = 1'b0;
    bus5.op    = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", bus8.busy, 1'b0);
    check_eq("rst_done", bus8.done, 1'b0);
    check_eq("rst_s", bus8.s, 0);
    check_eq("rst_ovf", bus8.ovf, 1'b0);
    check_eq("rst_w5_s", bus5.s, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op8(8'hFF, 8'h01, 1'b0);
    idle8();
    op8(8'h5A, 8'h3C, 1'b0);
    idle8();
    op8(8'h01, 8'h02, 1'b0);
    op8(8'h10, 8'h20, 1'b0);
    idle8();
    if (SUB_EN) begin
      op8(8'h10, 8'h01, 1'b1);
      idle8();
      op8(8'h80, 8'h01, 1'b1);
      op8(8'h00, 8'h01, 1'b1);
      idle8();
    end

    // Reset during the third RUN cycle must abort with no completion.
    bus8.a     = 8'h33;
    bus8.b     = 8'h44;
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", bus8.busy, 1'b0);
    check_eq("abort_done", bus8.done, 1'b0);
    check_eq("abort_s", bus8.s, 0);
    check_eq("abort_ovf", bus8.ovf, 1'b0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    prev_s8  = 0;
    prev_ov8 = 1'b0;
    saw_done = 1'b0;
    repeat (2 * L8) begin
      @(posedge clk); #1;
      if (bus8.done || bus8.busy) saw_done = 1'b1;
    end
    check_eq("abort_no_done", saw_done, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op8(8'($urandom), 8'($urandom), SUB_EN & 1'($urandom));
      if ($urandom_range(1, 0) == 1) idle8();
    end
    idle8();

    op5(5'h15, 5'h0A);
    for (int i = 0; i < 10; i++) op5(5'($urandom), 5'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
